ysyx_2022040010_mem_arbiter: RTL and testbench

//  Shares the single memory back-end between the IFU and LSU requesters. Classifies each granted

---
 rtl/ysyx_2022040010_mem_arbiter_pkg.sv | 18 +
 rtl/ysyx_2022040010_arb_pick.sv | 36 +++
 rtl/ysyx_2022040010_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_ysyx_2022040010_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_2022040010_mem_arbiter_pkg.sv
// rtl/ysyx_2022040010_mem_arbiter_pkg.sv - memory map, FSM encoding and cached-address classifier
package ysyx_2022040010_mem_arbiter_pkg;

  localparam logic [63:0] CONFIG_MBASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] CONFIG_MSIZE = 64'h0000_0000_1fff_ffff;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // Both bounds inclusive; everything else goes to the uncache bridge.
  function automatic logic is_cached(input logic [63:0] addr);
    return (addr >= CONFIG_MBASE) && (addr <= CONFIG_MBASE + CONFIG_MSIZE);
  endfunction

endpackage

// File: rtl/ysyx_2022040010_arb_pick.sv
// rtl/ysyx_2022040010_arb_pick.sv - 2-way IFU/LSU winner select (ARB_RR_EN: round-robin, else LSU priority)
module ysyx_2022040010_arb_pick
  import ysyx_2022040010_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic lsu_req,
  input  logic gnt_en,
  output logic pick_lsu
);

`ifdef ARB_RR_EN
  // 1 = the most recent grant went to the LSU; reset favours the LSU first.
  logic rr_last_lsu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_last_lsu <= 1'b0;
    else if (gnt_en)
      rr_last_lsu <= pick_lsu;
  end

  always_comb begin
    if (if_req && lsu_req)
      pick_lsu = !rr_last_lsu;
    else
      pick_lsu = lsu_req;
  end
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, rst, gnt_en, if_req};
  assign pick_lsu  = lsu_req;
`endif

endmodule

// File: rtl/ysyx_2022040010_mem_arbiter.sv
// rtl/ysyx_2022040010_mem_arbiter.sv - IFU/LSU arbiter to cache/uncache back-end (ARB_RR_EN selects round-robin)
module ysyx_2022040010_mem_arbiter
  import ysyx_2022040010_mem_arbiter_pkg::*;
#(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int UC_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            lsu_req,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            if_gnt,
  output logic            lsu_gnt,
  output logic            if_rvalid,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   rdata,
  output logic            rerr,
  output logic            c_req,
  output logic            uc_req,
  input  logic            c_ready,
  input  logic            uc_ready,
  output logic [AW-1:0]   m_addr,
  output logic            m_wen,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic            c_rvalid,
  input  logic            uc_rvalid,
  input  logic [DW-1:0]   c_rdata,
  input  logic [DW-1:0]   uc_rdata
);

  localparam int            CW     = $clog2(UC_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(UC_TIMEOUT);

  arb_state_e    state, state_nx;
  logic          owner_lsu, route_uc, fault;
  logic [CW-1:0] to_cnt;
  logic          pick_lsu, grant, busy, timeout, resp_in, done;
  logic          sel_cached;
  logic [AW-1:0] sel_addr;

  assign grant      = (state == ARB_IDLE) && (if_req || lsu_req);
  assign busy       = (state == ARB_ISSUE) || (state == ARB_WAIT);
  assign resp_in    = (state == ARB_WAIT) && (route_uc ? uc_rvalid : c_rvalid);
  assign timeout    = busy && route_uc && !fault && (to_cnt == TO_VAL);
  assign done       = resp_in || timeout || ((state == ARB_ISSUE) && fault);
  assign sel_addr   = pick_lsu ? lsu_addr : if_addr;
  assign sel_cached = is_cached(64'(sel_addr));

  ysyx_2022040010_arb_pick u_pick (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .lsu_req  (lsu_req),
    .gnt_en   (grant),
    .pick_lsu (pick_lsu)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ARB_IDLE;
    else
      state <= state_nx;
  end

  // Timeout is checked before ready so a dropped uc_req is never counted as accepted.
  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE:  if (grant) state_nx = ARB_ISSUE;
      ARB_ISSUE: begin
        if (fault || timeout)
          state_nx = ARB_IDLE;
        else if (route_uc ? uc_ready : c_ready)
          state_nx = ARB_WAIT;
      end
      ARB_WAIT:  if (resp_in || timeout) state_nx = ARB_IDLE;
      default:   state_nx = ARB_IDLE;
    endcase
  end

  always_comb begin
    if_gnt     = grant && rst && !pick_lsu;
    lsu_gnt    = grant && rst && pick_lsu;
    c_req      = (state == ARB_ISSUE) && !route_uc;
    uc_req     = (state == ARB_ISSUE) && route_uc && !fault && !timeout;
    if_rvalid  = done && !owner_lsu;
    lsu_rvalid = done && owner_lsu;
    rerr       = done && !resp_in;
    rdata      = '0;
    if (resp_in)
      rdata = route_uc ? uc_rdata : c_rdata;
  end

  // An uncached IFU fetch is a fault: it is granted but never sent downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_lsu <= 1'b1;
      route_uc  <= 1'b0;
      fault     <= 1'b0;
      m_addr    <= '0;
      m_wen     <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
    end else if (grant) begin
      owner_lsu <= pick_lsu;
      route_uc  <= !sel_cached;
      fault     <= !pick_lsu && !sel_cached;
      m_addr    <= sel_addr;
      m_wen     <= pick_lsu && lsu_wen;
      m_wdata   <= pick_lsu ? lsu_wdata : '0;
      m_wstrb   <= pick_lsu ? lsu_wstrb : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if (grant)
      to_cnt <= '0;
    else if (busy && (to_cnt != TO_VAL))
      to_cnt <= to_cnt + CW'(1);
  end

endmodule

// File: tb/tb_ysyx_2022040010_mem_arbiter.sv
// tb/tb_ysyx_2022040010_mem_arbiter.sv - directed vector bench for the memory arbiter (honours ARB_RR_EN)
module tb_ysyx_2022040010_mem_arbiter;

  localparam int UC_TO = 255;

  logic        clk, rst;
  logic        if_req, lsu_req, lsu_wen;
  logic [63:0] if_addr, lsu_addr, lsu_wdata;
  logic [7:0]  lsu_wstrb;
  logic        if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, rerr;
  logic [63:0] rdata;
  logic        c_req, uc_req, c_ready, uc_ready;
  logic [63:0] m_addr, m_wdata;
  logic        m_wen;
  logic [7:0]  m_wstrb;
  logic        c_rvalid, uc_rvalid;
  logic [63:0] c_rdata, uc_rdata;

  int errors = 0;
  int checks = 0;

  ysyx_2022040010_mem_arbiter #(.AW(64), .DW(64), .UC_TIMEOUT(UC_TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .if_gnt(if_gnt), .lsu_gnt(lsu_gnt), .if_rvalid(if_rvalid), .lsu_rvalid(lsu_rvalid),
    .rdata(rdata), .rerr(rerr),
    .c_req(c_req), .uc_req(uc_req), .c_ready(c_ready), .uc_ready(uc_ready),
    .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .c_rvalid(c_rvalid), .uc_rvalid(uc_rvalid), .c_rdata(c_rdata), .uc_rdata(uc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_lsu;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] resp;
    logic        exp_uc;
    logic        exp_fault;
    logic        exp_m_wen;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 0; lsu_req = 0; lsu_wen = 0;
    if_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wstrb = 0;
    c_ready = 0; uc_ready = 0; c_rvalid = 0; uc_rvalid = 0;
    c_rdata = 0; uc_rdata = 0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".ctl"}, {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, rerr, c_req, uc_req, m_wen}, 0);
    chk({name, ".rdata"}, rdata, 0);
    chk({name, ".m_addr"}, m_addr, 0);
    chk({name, ".m_wdata"}, m_wdata, 0);
    chk({name, ".m_wstrb"}, m_wstrb, 0);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    @(negedge clk);
    if_req    = !v.is_lsu;
    lsu_req   = v.is_lsu;
    if_addr   = v.is_lsu ? 64'h0 : v.addr;
    lsu_addr  = v.is_lsu ? v.addr : 64'h0;
    lsu_wen   = v.wen;
    lsu_wdata = v.wdata;
    lsu_wstrb = v.wstrb;
    #1;
    chk({tag, ".gnt"}, {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid}, {!v.is_lsu, v.is_lsu, 2'b00});
    @(negedge clk);
    if_req = 0; lsu_req = 0;
    #1;
    chk({tag, ".m_addr"}, m_addr, v.addr);
    chk({tag, ".m_wen"}, m_wen, v.exp_m_wen);
    if (v.is_lsu) begin
      chk({tag, ".m_wdata"}, m_wdata, v.wdata);
      chk({tag, ".m_wstrb"}, m_wstrb, v.wstrb);
    end
    if (v.exp_fault) begin
      chk({tag, ".fault"}, {if_rvalid, lsu_rvalid, rerr, c_req, uc_req}, 5'b10100);
    end else begin
      chk({tag, ".req"}, {c_req, uc_req}, {!v.exp_uc, v.exp_uc});
      @(negedge clk);
      #1;
      chk({tag, ".hold"}, {c_req, uc_req}, {!v.exp_uc, v.exp_uc});
      chk({tag, ".hold_addr"}, m_addr, v.addr);
      c_ready  = !v.exp_uc;
      uc_ready = v.exp_uc;
      @(negedge clk);
      c_ready = 0; uc_ready = 0;
      #1;
      chk({tag, ".wait"}, {c_req, uc_req, if_rvalid, lsu_rvalid}, 0);
      c_rvalid  = !v.exp_uc;
      uc_rvalid = v.exp_uc;
      c_rdata   = v.exp_uc ? 64'hBAD0_BAD0 : v.resp;
      uc_rdata  = v.exp_uc ? v.resp : 64'hBAD1_BAD1;
      #1;
      chk({tag, ".resp"}, {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, rerr},
          {2'b00, !v.is_lsu, v.is_lsu, 1'b0});
      chk({tag, ".rdata"}, rdata, v.exp_rdata);
      @(negedge clk);
      c_rvalid = 0; uc_rvalid = 0; c_rdata = 0; uc_rdata = 0;
    end
  endtask

  task automatic timeout_run(input bit tie, input string tag);
    int hit;
    hit = -1;
    @(negedge clk);
    lsu_req = 1; lsu_addr = 64'hA000_0008; lsu_wen = 0;
    #1;
    chk({tag, ".gnt"}, lsu_gnt, 1);
    @(negedge clk);
    lsu_req = 0;
    for (int k = 0; k <= UC_TO + 20 && hit < 0; k++) begin
      uc_ready  = (k == 2);
      uc_rvalid = tie && (k == UC_TO);
      uc_rdata  = 64'h77;
      #1;
      if (k < 2) chk({tag, ".uc_req"}, {uc_req, c_req}, 2'b10);
      if (lsu_rvalid) begin
        hit = k;
        chk({tag, ".rerr"}, rerr, tie ? 1'b0 : 1'b1);
        chk({tag, ".rdata"}, rdata, tie ? 64'h77 : 64'h0);
        chk({tag, ".uc_req_drop"}, uc_req, 0);
      end
      @(negedge clk);
    end
    uc_ready = 0; uc_rvalid = 0;
    chk({tag, ".cycles"}, hit, UC_TO);
    if (!tie) begin
      uc_rvalid = 1;
      #1;
      chk({tag, ".late_ignored"}, {if_rvalid, lsu_rvalid, uc_req}, 0);
      uc_rvalid = 0;
    end
    uc_rdata = 0;
  endtask

  task automatic arb_run();
    logic [3:0] exp_lsu;
`ifdef ARB_RR_EN
    exp_lsu = 4'b0101;
`else
    exp_lsu = 4'b1111;
`endif
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    if_req = 1; lsu_req = 1;
    if_addr = 64'h8000_0000; lsu_addr = 64'h8000_0008; lsu_wen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("arb%0d.gnt", i), {if_gnt, lsu_gnt}, {!exp_lsu[i], exp_lsu[i]});
      @(negedge clk);
      c_ready = 1;
      #1;
      chk($sformatf("arb%0d.busy", i), {if_gnt, lsu_gnt, c_req, uc_req}, 4'b0010);
      chk($sformatf("arb%0d.m_addr", i), m_addr, exp_lsu[i] ? 64'h8000_0008 : 64'h8000_0000);
      @(negedge clk);
      c_ready = 0; c_rvalid = 1; c_rdata = 64'(i + 16);
      #1;
      chk($sformatf("arb%0d.resp", i), {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid},
          {2'b00, !exp_lsu[i], exp_lsu[i]});
      chk($sformatf("arb%0d.rdata", i), rdata, 64'(i + 16));
      @(negedge clk);
      c_rvalid = 0; c_rdata = 0;
    end
    if_req = 0; lsu_req = 0;
  endtask

  initial begin
    //             lsu  addr                 wen  wdata              wstrb  resp              uc   flt  mwen rdata
    vecs[0] = '{1'b1, 64'h8000_0010, 1'b0, 64'h0,             8'h00, 64'hDEAD,         1'b0, 1'b0, 1'b0, 64'hDEAD};
    vecs[1] = '{1'b1, 64'h9FFF_FFFF, 1'b0, 64'h0,             8'h00, 64'h1234,         1'b0, 1'b0, 1'b0, 64'h1234};
    vecs[2] = '{1'b1, 64'hA000_0000, 1'b1, 64'h41,            8'h01, 64'h0,            1'b1, 1'b0, 1'b1, 64'h0};
    vecs[3] = '{1'b0, 64'h8000_0100, 1'b0, 64'h0,             8'h00, 64'h13,           1'b0, 1'b0, 1'b0, 64'h13};
    vecs[4] = '{1'b0, 64'h1000_0000, 1'b0, 64'h0,             8'h00, 64'h0,            1'b1, 1'b1, 1'b0, 64'h0};
    vecs[5] = '{1'b1, 64'h7FFF_FFFF, 1'b0, 64'h0,             8'h00, 64'h55,           1'b1, 1'b0, 1'b0, 64'h55};
    vecs[6] = '{1'b0, 64'h8000_0000, 1'b0, 64'h0,             8'h00, 64'h6F,           1'b0, 1'b0, 1'b0, 64'h6F};
    vecs[7] = '{1'b1, 64'h8000_0020, 1'b1, 64'hCAFE_F00D,     8'hF0, 64'h0,            1'b0, 1'b0, 1'b1, 64'h0};

    clear_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1;
    @(negedge clk);
    #1;
    chk_all_zero("post_reset");

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i], $sformatf("vec%0d", i));

    timeout_run(1'b0, "timeout");
    run_txn(vecs[0], "after_timeout");
    timeout_run(1'b1, "tie");

    @(negedge clk);
    lsu_req = 1; lsu_addr = 64'h8000_0010; lsu_wen = 1; lsu_wdata = 64'h99; lsu_wstrb = 8'hFF;
    #1;
    chk("rst_wait.gnt", lsu_gnt, 1);
    @(negedge clk);
    lsu_req = 0; c_ready = 1;
    @(negedge clk);
    c_ready = 0;
    #1;
    chk("rst_wait.in_wait", {c_req, lsu_rvalid}, 0);
    lsu_req = 1; c_rvalid = 1; c_rdata = 64'hDEAD;
    rst = 0;
    #1;
    chk_all_zero("rst_wait");
    @(negedge clk);
    c_rvalid = 0; c_rdata = 0; lsu_req = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wstrb = 0;
    rst = 1;
    run_txn(vecs[0], "post_rst");

    arb_run();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
